// File: rtl/gravador_memoria_jogadas.sv
// Records switch nibbles into a 16-entry RAM, one word per button press.
// FSM control unit with counter, data register, edge detector and debug 7-seg.
module gravador_memoria_jogadas #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [DATA_W-1:0] chaves,
  input  logic              gravar,
  input  logic [ADDR_W-1:0] endereco_leitura,
  output logic [DATA_W-1:0] dado_leitura,
  output logic              pronto,
  output logic              gravando,
  output logic              db_gravar,
  output logic [6:0]        db_endereco,
  output logic [6:0]        db_dado,
  output logic [6:0]        db_estado
);

  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARACAO = 4'h1,
    ESPERA     = 4'h2,
    REGISTRA   = 4'h3,
    ESCREVE    = 4'h4,
    PROXIMO    = 4'h5,
    FIM        = 4'hF
  } estado_t;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  estado_t             r_estado;
  estado_t             w_prox;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_reg;
  logic                r_gravar_d;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic w_pulso;
  logic w_zera;
  logic w_conta;
  logic w_registra;
  logic w_we;
  logic w_fimc;

  function automatic logic [6:0] hexa7seg(input logic [3:0] v);
    logic [6:0] s;
    s = 7'b1111111;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign w_pulso = gravar & ~r_gravar_d;
  assign w_fimc  = (r_cnt == LAST);

  // Button delay flop; resets high so a held button cannot fire.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_gravar_d <= 1'b1;
    else        r_gravar_d <= gravar;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado <= INICIAL;
    else        r_estado <= w_prox;
  end

  // Next-state and control signals.
  always_comb begin
    w_prox     = r_estado;
    w_zera     = 1'b0;
    w_conta    = 1'b0;
    w_registra = 1'b0;
    w_we       = 1'b0;
    pronto     = 1'b0;
    gravando   = 1'b0;
    unique case (r_estado)
      INICIAL: begin
        if (iniciar) w_prox = PREPARACAO;
      end
      PREPARACAO: begin
        w_zera = 1'b1;
        w_prox = ESPERA;
      end
      ESPERA: begin
        gravando = 1'b1;
        if (w_pulso) w_prox = REGISTRA;
      end
      REGISTRA: begin
        gravando   = 1'b1;
        w_registra = 1'b1;
        w_prox     = ESCREVE;
      end
      ESCREVE: begin
        gravando = 1'b1;
        w_we     = 1'b1;
        w_prox   = w_fimc ? FIM : PROXIMO;
      end
      PROXIMO: begin
        gravando = 1'b1;
        w_conta  = 1'b1;
        w_prox   = ESPERA;
      end
      FIM: begin
        pronto = 1'b1;
        if (iniciar) w_prox = PREPARACAO;
      end
      default: w_prox = INICIAL;
    endcase
  end

  // Address counter: cleared in preparacao, stepped in proximo.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       r_cnt <= '0;
    else if (w_zera)  r_cnt <= '0;
    else if (w_conta) r_cnt <= r_cnt + 1'b1;
  end

  // Data register: cleared in preparacao, loads switches in registra.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          r_reg <= '0;
    else if (w_zera)     r_reg <= '0;
    else if (w_registra) r_reg <= chaves;
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (w_we) r_mem[r_cnt] <= r_reg;
  end

  assign dado_leitura = r_mem[endereco_leitura];
  assign db_gravar    = w_pulso;
  assign db_endereco  = hexa7seg(4'(r_cnt));
  assign db_dado      = hexa7seg(4'(r_reg));
  assign db_estado    = hexa7seg(4'(r_estado));

endmodule

// File: tb/tb_gravador_memoria_jogadas.sv
// Bench for gravador_memoria_jogadas: spec-level model plus directed checks.
// Compares every cycle at the falling edge; inputs change 1ns after it.
module tb_gravador_memoria_jogadas;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar = 1'b0;
  logic [3:0] chaves = 4'h0;
  logic       gravar = 1'b0;
  logic [3:0] endereco_leitura = 4'h0;
  logic [3:0] dado_leitura;
  logic       pronto, gravando, db_gravar;
  logic [6:0] db_endereco, db_dado, db_estado;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  gravador_memoria_jogadas dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .chaves(chaves), .gravar(gravar),
    .endereco_leitura(endereco_leitura),
    .dado_leitura(dado_leitura), .pronto(pronto),
    .gravando(gravando), .db_gravar(db_gravar),
    .db_endereco(db_endereco), .db_dado(db_dado),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] seg(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  // Model of the recorder at the level of the written rules.
  int         m_code = 0;
  int         m_addr = 0;
  logic [3:0] m_reg = 4'h0;
  bit         m_gd = 1'b1;
  logic [3:0] m_mem [16];
  bit         m_known [16];
  bit         p;

  initial for (int i = 0; i < 16; i++) m_known[i] = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_code = 0; m_addr = 0; m_reg = 4'h0; m_gd = 1'b1;
    end else begin
      p = gravar && !m_gd;
      m_gd = gravar;
      case (m_code)
        0:  if (iniciar) m_code = 1;
        1:  begin m_addr = 0; m_reg = 4'h0; m_code = 2; end
        2:  if (p) m_code = 3;
        3:  begin m_reg = chaves; m_code = 4; end
        4:  begin
              m_mem[m_addr] = m_reg;
              m_known[m_addr] = 1'b1;
              m_code = (m_addr == 15) ? 15 : 5;
            end
        5:  begin m_addr = m_addr + 1; m_code = 2; end
        15: if (iniciar) m_code = 1;
        default: m_code = 0;
      endcase
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("estado", db_estado, seg(4'(m_code)));
      chk("endereco", db_endereco, seg(4'(m_addr)));
      chk("dado", db_dado, seg(m_reg));
      chk("pronto", pronto, (m_code == 15));
      chk("gravando", gravando, (m_code >= 2 && m_code <= 5));
      chk("db_gravar", db_gravar, (gravar && !m_gd));
      if (m_known[endereco_leitura])
        chk("leitura", dado_leitura, m_mem[endereco_leitura]);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  // One record transaction; optional extra press sampled at edge E2 or E3.
  task automatic rec(input logic [3:0] v, input int glitch);
    chaves = v; gravar = 1'b1;
    tick();
    gravar = 1'b0;
    tick();
    chaves = ~v;
    if (glitch == 2) gravar = 1'b1;
    tick();
    gravar = (glitch == 3);
    tick();
    gravar = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] exp, input string nm);
    endereco_leitura = a;
    #1;
    chk(nm, dado_leitura, exp);
  endtask

  initial begin
    reset = 1'b0;
    gravar = 1'b1;
    #1;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    chk_en = 1'b1;
    tick(2);
    chk("rst_db_gravar", db_gravar, 0);
    chk("rst_estado", db_estado, 7'h40);
    chk("rst_pronto", pronto, 0);
    chk("rst_endereco", db_endereco, 7'h40);
    gravar = 1'b0;
    tick();

    iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
    chaves = 4'hA; gravar = 1'b1;
    tick(2);
    chk("held_not_yet", db_estado, seg(4'h4));
    tick();
    rd(4'h0, 4'hA, "held_write_E2");
    tick();
    chk("held_cnt_E3", db_endereco, seg(4'h1));
    chk("held_estado_E3", db_estado, seg(4'h2));
    tick();
    gravar = 1'b0;
    tick();
    chk("held_once", db_endereco, seg(4'h1));

    for (int i = 1; i < 16; i++) rec(4'(i), 0);
    chk("fim_estado_a", db_estado, seg(4'hF));

    iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
    for (int i = 0; i < 16; i++) rec(4'(i), 0);
    chk("fim_estado", db_estado, seg(4'hF));
    chk("fim_pronto", pronto, 1);
    chk("fim_cnt", db_endereco, seg(4'hF));
    for (int i = 0; i < 16; i++) rd(4'(i), 4'(i), "readback");
    chaves = 4'h0;
    rec(4'h9, 0);
    rd(4'hF, 4'hF, "fim_nowrite");
    chk("fim_hold_cnt", db_endereco, seg(4'hF));

    iniciar = 1'b1; tick();
    iniciar = 1'b0; gravar = 1'b1; tick();
    gravar = 1'b0; tick();
    chk("prep_drop_cnt", db_endereco, seg(4'h0));
    chk("prep_drop_st", db_estado, seg(4'h2));
    rec(4'h5, 0);
    rd(4'h0, 4'h5, "rerec_a0");
    rd(4'h1, 4'h1, "rerec_a1");
    rec(4'hC, 2);
    rec(4'hD, 3);
    rec(4'h2, 0);
    chk("glitch_cnt", db_endereco, seg(4'h4));
    rd(4'h1, 4'hC, "glitch_a1");
    rd(4'h2, 4'hD, "glitch_a2");
    rd(4'h3, 4'h2, "glitch_a3");

    reset = 1'b0; tick(); reset = 1'b1; tick();
    iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
    rec(4'hE, 0);
    rec(4'hB, 0);
    rec(4'h6, 0);
    chaves = 4'h7; gravar = 1'b1;
    tick();
    gravar = 1'b0;
    tick();
    chk("abort_in_escreve", db_estado, seg(4'h4));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    rd(4'h3, 4'h2, "abort_a3");
    rd(4'h0, 4'hE, "abort_a0");
    rd(4'h1, 4'hB, "abort_a1");
    rd(4'h2, 4'h6, "abort_a2");
    chk("abort_estado", db_estado, seg(4'h0));
    chk("abort_cnt", db_endereco, seg(4'h0));
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
